// File: rtl/pattern_detector_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding and a
// helper that sizes the fill counter for a given pattern length.
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } pd_state_e;

  function automatic int fill_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/pd_history.sv
// Serial history shift register plus saturating fill counter. Only W-1 past
// bits are stored; the live input completes the W-bit comparison window.
module pd_history
  import pattern_detector_pkg::*;
#(
  parameter int W  = 4,
  parameter int FW = fill_bits(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          shift,
  input  logic          restart,
  input  logic          zero,
  input  logic          in,
  output logic [W-1:0]  window,
  output logic [FW-1:0] fill
);

  logic [W-2:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;

  assign window = {hist_q, in};
  assign fill   = fill_q;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (zero) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = window[W-2:0];
      if (restart)               fill_d = '0;
      else if (fill_q != FW'(W)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: loadable pattern, sticky/pulse match, optional
// overlapping detection and a saturating match counter.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int                   PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PAT_RESET = 4'b0110,
  parameter int                   CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 valid,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 sticky,
  input  logic                 overlap,
  output logic                 match,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam int FW = fill_bits(PAT_WIDTH);

  pd_state_e              state_q, state_d;
  logic [PAT_WIDTH-1:0]   pat_q, pat_d;
  logic                   match_q, match_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PAT_WIDTH-1:0]   window;
  logic [FW-1:0]          fill;
  logic                   accept, full, hit;

  // A locked detector ignores the stream until clear, load or reset.
  assign accept = valid && !load && !clear && (state_q != LOCKED);
  assign full   = (fill >= FW'(PAT_WIDTH - 1));
  assign hit    = accept && full && (window == pat_q);

  pd_history #(.W(PAT_WIDTH), .FW(FW)) u_hist (
    .clock   (clock),
    .reset   (reset),
    .shift   (accept),
    .restart (hit && !overlap),
    .zero    (load || clear),
    .in      (in),
    .window  (window),
    .fill    (fill)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    match_d = (state_q == LOCKED);
    if (load || clear) begin
      state_d = FILL;
      match_d = 1'b0;
      if (load)  pat_d = pattern;
      if (clear) cnt_d = '0;
    end else if (accept) begin
      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (sticky)       state_d = LOCKED;
        else if (overlap) state_d = ARMED;
        else              state_d = FILL;
      end else begin
        state_d = full ? ARMED : FILL;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      pat_q   <= PAT_RESET;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = match_q;
  assign locked      = (state_q == LOCKED);
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: a vector table for the main modes plus
// hand-written sequences for counter saturation and asynchronous reset.
module tb_pattern_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       in, valid, load, clear, sticky, overlap;
  logic [3:0] pattern;
  logic       match_a, locked_a, match_b, locked_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       valid, in, load, clear, sticky, overlap;
    logic [3:0] pattern;
    logic       em, el;
    int         ec;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  pattern_detector #(.PAT_WIDTH(4), .PAT_RESET(4'b0110), .CNT_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .in(in), .valid(valid), .pattern(pattern),
    .load(load), .clear(clear), .sticky(sticky), .overlap(overlap),
    .match(match_a), .locked(locked_a), .match_count(cnt_a));

  pattern_detector #(.PAT_WIDTH(4), .PAT_RESET(4'b0110), .CNT_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .in(in), .valid(valid), .pattern(pattern),
    .load(load), .clear(clear), .sticky(sticky), .overlap(overlap),
    .match(match_b), .locked(locked_b), .match_count(cnt_b));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic v(input logic vl, input logic i, input logic ld, input logic cl,
                   input logic s, input logic o, input logic [3:0] p,
                   input logic em, input logic el, input int ec);
    vec_t t;
    t.valid = vl; t.in = i; t.load = ld; t.clear = cl; t.sticky = s; t.overlap = o;
    t.pattern = p; t.em = em; t.el = el; t.ec = ec;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic vl, input logic i, input logic s, input logic o);
    valid = vl; in = i; load = 1'b0; clear = 1'b0; sticky = s; overlap = o;
  endtask

  // Non-overlapping, non-sticky serial sample
  task automatic send(input logic b);
    drive(1'b1, b, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    reset = 1'b1; in = 0; valid = 0; load = 0; clear = 0; sticky = 0; overlap = 0;
    pattern = 4'b0110;
    #1;
    chk("reset_match", match_a, 0);
    chk("reset_locked", locked_a, 0);
    chk("reset_count", cnt_a, 0);
    step(); step();
    reset = 1'b0;

    // default pattern 0110, pulse mode, overlap on
    v(1,0,0,0,0,1,4'b0110, 0,0,0);
    v(1,1,0,0,0,1,4'b0110, 0,0,0);
    v(1,1,0,0,0,1,4'b0110, 0,0,0);
    v(1,0,0,0,0,1,4'b0110, 1,0,1);
    v(0,0,0,0,0,1,4'b0110, 0,0,1);
    // clear, then 0110 with idle gaps (in toggles while invalid)
    v(0,0,0,1,0,1,4'b0110, 0,0,0);
    v(1,0,0,0,0,1,4'b0110, 0,0,0);
    v(0,1,0,0,0,1,4'b0110, 0,0,0);
    v(1,1,0,0,0,1,4'b0110, 0,0,0);
    v(0,0,0,0,0,1,4'b0110, 0,0,0);
    v(0,0,0,0,0,1,4'b0110, 0,0,0);
    v(1,1,0,0,0,1,4'b0110, 0,0,0);
    v(0,1,0,0,0,1,4'b0110, 0,0,0);
    v(1,0,0,0,0,1,4'b0110, 1,0,1);
    v(0,0,0,0,0,1,4'b0110, 0,0,1);
    v(0,0,0,0,0,1,4'b0110, 0,0,1);
    // load 1010 colliding with a valid sample: sample dropped, count kept
    v(1,1,1,0,0,1,4'b1010, 0,0,1);
    v(1,1,0,0,0,1,4'b0110, 0,0,1);
    v(1,0,0,0,0,1,4'b0110, 0,0,1);
    v(1,1,0,0,0,1,4'b0110, 0,0,1);
    v(1,0,0,0,0,1,4'b0110, 1,0,2);
    v(1,1,0,0,0,1,4'b0110, 0,0,2);
    v(1,0,0,0,0,1,4'b0110, 1,0,3);
    v(0,0,0,0,0,1,4'b0110, 0,0,3);
    // overlap off: history restarts after each hit
    v(0,0,0,1,0,0,4'b0110, 0,0,0);
    v(1,1,0,0,0,0,4'b0110, 0,0,0);
    v(1,0,0,0,0,0,4'b0110, 0,0,0);
    v(1,1,0,0,0,0,4'b0110, 0,0,0);
    v(1,0,0,0,0,0,4'b0110, 1,0,1);
    v(1,1,0,0,0,0,4'b0110, 0,0,1);
    v(1,0,0,0,0,0,4'b0110, 0,0,1);
    v(1,1,0,0,0,0,4'b0110, 0,0,1);
    v(1,0,0,0,0,0,4'b0110, 1,0,2);
    v(0,0,0,0,0,0,4'b0110, 0,0,2);
    // load and clear together: pattern 0110, counter zeroed
    v(1,1,1,1,0,0,4'b0110, 0,0,0);
    // sticky lock: later samples and mode changes do not disturb it
    v(1,0,0,0,1,1,4'b0110, 0,0,0);
    v(1,1,0,0,1,1,4'b0110, 0,0,0);
    v(1,1,0,0,1,1,4'b0110, 0,0,0);
    v(1,0,0,0,1,1,4'b0110, 1,1,1);
    v(1,1,0,0,1,1,4'b0110, 1,1,1);
    v(1,1,0,0,1,1,4'b0110, 1,1,1);
    v(1,1,0,0,1,1,4'b0110, 1,1,1);
    v(1,1,0,0,1,1,4'b0110, 1,1,1);
    v(1,1,0,0,0,0,4'b0110, 1,1,1);
    v(0,0,0,0,0,0,4'b0110, 1,1,1);
    v(0,0,0,1,0,0,4'b0110, 0,0,0);

    foreach (vecs[k]) begin
      valid = vecs[k].valid; in = vecs[k].in; load = vecs[k].load;
      clear = vecs[k].clear; sticky = vecs[k].sticky; overlap = vecs[k].overlap;
      pattern = vecs[k].pattern;
      step();
      chk($sformatf("vec%0d_match", k), match_a, vecs[k].em);
      chk($sformatf("vec%0d_locked", k), locked_a, vecs[k].el);
      chk($sformatf("vec%0d_count", k), cnt_a, vecs[k].ec);
    end

    // five non-overlapping detections: 8-bit counter 5, 2-bit counter saturates
    for (int r = 0; r < 5; r++) begin
      send(0); send(1); send(1); send(0);
      chk($sformatf("sat_match%0d", r), match_a, 1);
    end
    chk("sat_count_a", cnt_a, 5);
    chk("sat_count_b", cnt_b, 3);
    drive(0, 0, 0, 0);
    step();
    chk("sat_hold_b", cnt_b, 3);

    // reset mid-pattern acts without a clock edge and drops the partial history
    send(0); send(1);
    reset = 1'b1;
    #1;
    chk("arst_count_a", cnt_a, 0);
    chk("arst_count_b", cnt_b, 0);
    chk("arst_match", match_a, 0);
    chk("arst_locked", locked_a, 0);
    drive(1, 1, 0, 0);
    step();
    chk("rst_hold_count", cnt_a, 0);
    #1 reset = 1'b0;
    send(1); send(0);
    chk("rst_partial_dropped", match_a, 0);
    send(0); send(1); send(1);
    chk("rst_no_early", match_a, 0);
    send(0);
    chk("rst_match", match_a, 1);
    chk("rst_count", cnt_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
